// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scanner: active-high hex patterns,
// the all-off pattern and a one-hot helper for digit selects.
package seg7_pkg;

  // Index = hex value; bit order {g,f,e,d,c,b,a}, active-high.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_OFF    = 7'h00;
  localparam int         MAX_DIGITS = 8;

  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] sel_idx);
    return MAX_DIGITS'(1) << sel_idx;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex-to-7-segment decoder, active-high {g,f,e,d,c,b,a}.
// Polarity adjustment is left to the instantiating scanner.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scanner with double-buffered digit data,
// leading-zero blanking and registered outputs (one clock behind scan state).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DWELL          = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [6:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] SEL_INV = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

  logic [IDX_W-1:0]        idx;
  logic [CNT_W-1:0]        dwell_cnt;
  logic [4*NUM_DIGITS-1:0] shadow_bcd, disp_bcd;
  logic [NUM_DIGITS-1:0]   shadow_dp, disp_dp;
  logic                    pending;

  logic dwell_end, last_digit, commit;

  assign dwell_end  = (dwell_cnt == CNT_W'(DWELL - 1));
  assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
  assign commit     = dwell_end && last_digit;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      idx        <= '0;
      dwell_cnt  <= '0;
      shadow_bcd <= '0;
      shadow_dp  <= '0;
      disp_bcd   <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
    end else begin
      if (dwell_end) begin
        dwell_cnt <= '0;
        idx       <= last_digit ? '0 : idx + 1'b1;
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end

      // A load landing on the commit edge goes straight to the display.
      if (commit) begin
        if (pending || load) begin
          disp_bcd <= load ? bcd_in : shadow_bcd;
          disp_dp  <= load ? dp_in  : shadow_dp;
        end
        pending <= 1'b0;
      end else if (load) begin
        shadow_bcd <= bcd_in;
        shadow_dp  <= dp_in;
        pending    <= 1'b1;
      end
    end
  end

  logic [3:0] cur_hex;
  logic       cur_dp;
  logic       cur_lz;
  logic       zeros_above;

  // Scan from the top digit down; a digit is a leading zero while everything above it is zero.
  always_comb begin
    cur_hex     = 4'h0;
    cur_dp      = 1'b0;
    cur_lz      = 1'b0;
    zeros_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zeros_above = zeros_above && (disp_bcd[4*k +: 4] == 4'h0);
      if (idx == IDX_W'(k)) begin
        cur_hex = disp_bcd[4*k +: 4];
        cur_dp  = disp_dp[k];
        cur_lz  = zeros_above && (k != 0);
      end
    end
  end

  logic [6:0] hex_seg;

  seg7_hex_decoder u_dec (
    .hex (cur_hex),
    .seg (hex_seg)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      seg_out     <= SEG_INV;
      dp_out      <= DP_INV;
      digit_sel   <= SEL_INV;
      frame_start <= 1'b0;
    end else begin
      seg_out     <= ((blank_lz && cur_lz) ? SEG_OFF : hex_seg) ^ SEG_INV;
      dp_out      <= cur_dp ^ DP_INV;
      digit_sel   <= NUM_DIGITS'(onehot(3'(idx))) ^ SEL_INV;
      frame_start <= (idx == '0) && (dwell_cnt == '0);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: an active-high DWELL=1 instance and an
// active-low DWELL=3 instance share stimulus; expectations go through queues.
module tb_seg7_scan_driver;

  typedef struct packed {
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } out_t;

  localparam logic [6:0] HEX_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  localparam out_t IDLE_HI = out_t'({4'b0000, 7'h00, 1'b0, 1'b0});
  localparam out_t IDLE_LO = out_t'({4'b1111, 7'h7F, 1'b1, 1'b0});

  logic        clk_in;
  logic        rst;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        blank_lz;

  logic [6:0] seg1, seg3;
  logic       dp1, dp3, fs1, fs3;
  logic [3:0] sel1, sel3;

  out_t got1, got3;
  assign got1 = {sel1, seg1, dp1, fs1};
  assign got3 = {sel3, seg3, dp3, fs3};

  int   checks = 0;
  int   errors = 0;
  out_t exp_q[$];
  out_t exp3_q[$];

  seg7_scan_driver #(.NUM_DIGITS(4), .DWELL(1), .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)) dut (
    .clk_in(clk_in), .rst(rst), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg_out(seg1), .dp_out(dp1), .digit_sel(sel1),
    .frame_start(fs1)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .DWELL(3), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) dut3 (
    .clk_in(clk_in), .rst(rst), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg_out(seg3), .dp_out(dp3), .digit_sel(sel3),
    .frame_start(fs3)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Active-high expectation for digit d of a display word.
  function automatic out_t exp_out(input int d, input logic [15:0] disp,
                                   input logic [3:0] dps, input logic blk,
                                   input logic fs);
    out_t        o;
    logic [15:0] upper;
    upper = disp >> (4 * d);
    o.sel = 4'b0001 << d;
    o.seg = (blk && d != 0 && upper == 16'h0) ? 7'h00 : HEX_TBL[upper[3:0]];
    o.dp  = dps[d];
    o.fs  = fs;
    return o;
  endfunction

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset;
    rst  = 1'b1;
    load = 1'b0;
    tick();
    rst  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; load = 1'b0; blank_lz = 1'b0; bcd_in = 16'h0; dp_in = 4'h0;
    tick();
    tick();
    checks++;
    if (got1 !== IDLE_HI) begin
      errors++;
      $display("FAIL reset_hi: got %h expected %h", got1, IDLE_HI);
    end
    checks++;
    if (got3 !== IDLE_LO) begin
      errors++;
      $display("FAIL reset_lo: got %h expected %h", got3, IDLE_LO);
    end
  endtask

  task automatic test_scan;
    out_t e;
    int   k = 0;
    do_reset();
    for (int i = 0; i < 12; i++) exp_q.push_back(exp_out(i % 4, 16'h0, 4'h0, 1'b0, (i % 4) == 0));
    while (exp_q.size() > 0) begin
      tick();
      k++;
      e = exp_q.pop_front();
      checks++;
      if (got1 !== e) begin
        errors++;
        $display("FAIL scan edge %0d: got %h expected %h", k, got1, e);
      end
    end
  endtask

  task automatic test_dwell;
    out_t e;
    int   k = 0;
    do_reset();
    for (int i = 0; i < 26; i++) begin
      e = out_t'({~(4'b0001 << ((i / 3) % 4)), 7'h40, 1'b1, (i % 12) == 0});
      exp3_q.push_back(e);
    end
    while (exp3_q.size() > 0) begin
      tick();
      k++;
      e = exp3_q.pop_front();
      checks++;
      if (got3 !== e) begin
        errors++;
        $display("FAIL dwell edge %0d: got %h expected %h", k, got3, e);
      end
    end
  endtask

  task automatic test_load;
    out_t e;
    int   k = 0;
    do_reset();
    for (int i = 1; i <= 12; i++)
      exp_q.push_back(exp_out((i - 1) % 4, (i <= 4) ? 16'h0 : 16'h1234,
                              (i <= 4) ? 4'h0 : 4'b0010, 1'b0, ((i - 1) % 4) == 0));
    while (exp_q.size() > 0) begin
      tick();
      k++;
      e = exp_q.pop_front();
      checks++;
      if (got1 !== e) begin
        errors++;
        $display("FAIL load edge %0d: got %h expected %h", k, got1, e);
      end
      if (k == 1) begin
        load = 1'b1; bcd_in = 16'h1234; dp_in = 4'b0010;
      end else if (k == 2) begin
        load = 1'b0; bcd_in = 16'hDEAD; dp_in = 4'b1111;
      end
    end
  endtask

  task automatic test_blank;
    out_t        e;
    int          k = 0;
    logic [15:0] fv[4];
    logic [3:0]  fd[4];
    fv = '{16'h0000, 16'h0070, 16'h0000, 16'hA000};
    fd = '{4'b0000, 4'b0000, 4'b1000, 4'b0000};
    blank_lz = 1'b1;
    do_reset();
    for (int f = 0; f < 4; f++)
      for (int d = 0; d < 4; d++) exp_q.push_back(exp_out(d, fv[f], fd[f], 1'b1, d == 0));
    while (exp_q.size() > 0) begin
      tick();
      k++;
      e = exp_q.pop_front();
      checks++;
      if (got1 !== e) begin
        errors++;
        $display("FAIL blank edge %0d: got %h expected %h", k, got1, e);
      end
      if ((k % 4) == 1 && k < 13) begin
        load = 1'b1; bcd_in = fv[k / 4 + 1]; dp_in = fd[k / 4 + 1];
      end else begin
        load = 1'b0;
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_back_to_back;
    out_t        e;
    int          k = 0;
    logic [15:0] v;
    logic [3:0]  p;
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      v = (i <= 4) ? 16'h0 : (i <= 8) ? 16'h5678 : 16'h9ABC;
      p = (i <= 4) ? 4'h0 : (i <= 8) ? 4'b0001 : 4'b1000;
      exp_q.push_back(exp_out((i - 1) % 4, v, p, 1'b0, ((i - 1) % 4) == 0));
    end
    while (exp_q.size() > 0) begin
      tick();
      k++;
      e = exp_q.pop_front();
      checks++;
      if (got1 !== e) begin
        errors++;
        $display("FAIL back_to_back edge %0d: got %h expected %h", k, got1, e);
      end
      if (k == 3) begin
        load = 1'b1; bcd_in = 16'h5678; dp_in = 4'b0001;
      end else if (k == 4) begin
        bcd_in = 16'h9ABC; dp_in = 4'b1000;
      end else if (k == 5) begin
        load = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid;
    out_t e;
    int   k = 0;
    do_reset();
    exp_q.push_back(exp_out(0, 16'h0, 4'h0, 1'b0, 1'b1));
    exp_q.push_back(exp_out(1, 16'h0, 4'h0, 1'b0, 1'b0));
    exp_q.push_back(IDLE_HI);
    for (int i = 0; i < 8; i++) exp_q.push_back(exp_out(i % 4, 16'h0, 4'h0, 1'b0, (i % 4) == 0));
    while (exp_q.size() > 0) begin
      tick();
      k++;
      e = exp_q.pop_front();
      checks++;
      if (got1 !== e) begin
        errors++;
        $display("FAIL reset_mid edge %0d: got %h expected %h", k, got1, e);
      end
      if (k == 1) begin
        load = 1'b1; bcd_in = 16'h1111; dp_in = 4'b1111;
      end else if (k == 2) begin
        load = 1'b0; rst = 1'b1;
      end else if (k == 3) begin
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_dwell();
    test_load();
    test_blank();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
